// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle MIPS control unit and its datapath:
// FSM state encoding, opcode/funct values, ALU operation classes, ALU control
// codes and the alusrcb / pcsrc mux encodings.
// No ports.
// -----------------------------------------------------------------------------
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU operation class chosen by the FSM
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // ALU control codes seen by the datapath ALU
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
  localparam logic [1:0] PCSRC_JUMP      = 2'b10;

endpackage

// File: rtl/mc_controller_if.sv
// -----------------------------------------------------------------------------
// mc_controller_if
// Bundle between the control unit and the multicycle datapath.
//   Datapath -> controller : op, funct, zero
//   Controller -> datapath : pcen, irwrite, regwrite, memwrite, alusrca, iord,
//                            memtoreg, regdst, alusrcb, pcsrc, alucontrol
// Modports: master = control unit, slave = datapath.
// -----------------------------------------------------------------------------
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       irwrite;
  logic       regwrite;
  logic       memwrite;
  logic       alusrca;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;

  modport master (
    input  op, funct, zero,
    output pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg,
           regdst, alusrcb, pcsrc, alucontrol
  );

  modport slave (
    output op, funct, zero,
    input  pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg,
           regdst, alusrcb, pcsrc, alucontrol
  );
endinterface

// File: rtl/mc_aludec.sv
// -----------------------------------------------------------------------------
// mc_aludec
// Combinational ALU decoder: maps the FSM's ALU operation class and the
// instruction funct field to the 3-bit ALU control code.
//   aluop      in  2 : operation class (add / sub / funct)
//   funct      in  6 : instr[5:0]
//   alucontrol out 3 : ALU control code
// -----------------------------------------------------------------------------
module mc_aludec
  import mc_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALUC_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALUC_ADD;
      ALUOP_SUB: alucontrol = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALUC_ADD;
          FUNCT_SUB: alucontrol = ALUC_SUB;
          FUNCT_AND: alucontrol = ALUC_AND;
          FUNCT_OR:  alucontrol = ALUC_OR;
          FUNCT_SLT: alucontrol = ALUC_SLT;
          // Unsupported functs fall back to add so the datapath stays benign
          default:   alucontrol = ALUC_ADD;
        endcase
      end
      default: alucontrol = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
// Multicycle MIPS control unit. A Moore FSM steps through one instruction at a
// time and drives every datapath select/enable; mc_aludec turns the state's ALU
// operation class plus funct into alucontrol.
//   clk     in      1 : system clock, rising edge
//   reset   in      1 : asynchronous reset, active low
//   bus     master    : op/funct/zero in, all control lines out
//   instret out    32 : retired-instruction count (only with MC_PERFCNT_EN)
// Optional feature macro: MC_PERFCNT_EN adds the instret counter and port.
// -----------------------------------------------------------------------------
module mc_controller
  import mc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mc_controller_if.master   bus
`ifdef MC_PERFCNT_EN
  ,
  output logic [31:0]       instret
`endif
);

  state_t     state_reg;
  state_t     state_next;
  aluop_t     aluop;
  logic       pcwrite;
  logic       branch;
  logic       irwrite;
  logic       regwrite;
  logic       memwrite;
  logic       alusrca;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    aluop      = ALUOP_ADD;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = SRCB_B;
    pcsrc      = PCSRC_ALURESULT;

    case (state_reg)
      S_FETCH: begin
        irwrite    = 1'b1;
        pcwrite    = 1'b1;
        alusrcb    = SRCB_FOUR;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here into ALUOut
        alusrcb = SRCB_IMMSH2;
        case (bus.op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEXEC;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;  // unknown op retires as a nop
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        state_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        branch  = 1'b1;
        pcsrc   = PCSRC_ALUOUT;
        aluop   = ALUOP_SUB;
      end
      S_ADDIEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
      end
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = PCSRC_JUMP;
      end
      default: state_next = S_FETCH;
    endcase
  end

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol)
  );

  // zero only matters during BRANCH, where branch is the sole term that can
  // make pcen depend on it
  assign bus.pcen     = pcwrite | (branch & bus.zero);
  assign bus.irwrite  = irwrite;
  assign bus.regwrite = regwrite;
  assign bus.memwrite = memwrite;
  assign bus.alusrca  = alusrca;
  assign bus.iord     = iord;
  assign bus.memtoreg = memtoreg;
  assign bus.regdst   = regdst;
  assign bus.alusrcb  = alusrcb;
  assign bus.pcsrc    = pcsrc;

`ifdef MC_PERFCNT_EN
  logic        retire;
  logic [31:0] instret_reg;

  // Every terminal state returns to FETCH on the next edge, so being in one
  // of them means the instruction retires on this edge
  always_comb begin
    retire = 1'b0;
    case (state_reg)
      S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      instret_reg <= 32'd0;
    else if (retire) instret_reg <= instret_reg + 32'd1;  // wraps silently
  end

  assign instret = instret_reg;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_controller
// Directed, table-driven bench for mc_controller. Each table row is one clock
// cycle: the op/funct/zero presented and the expected control word (and
// instret when MC_PERFCNT_EN is defined). Reset behaviour is checked by hand.
// -----------------------------------------------------------------------------
module tb_mc_controller;

  logic clk;
  logic reset;
`ifdef MC_PERFCNT_EN
  logic [31:0] instret;
`endif

  mc_controller_if bus ();

  mc_controller dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus)
`ifdef MC_PERFCNT_EN
    ,
    .instret (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: {pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg,
  //                regdst, alusrcb[1:0], pcsrc[1:0], alucontrol[2:0]}
  localparam logic [14:0] W_FETCH    = {8'b11000000, 2'b01, 2'b00, 3'b010};
  localparam logic [14:0] W_DECODE   = {8'b00000000, 2'b11, 2'b00, 3'b010};
  localparam logic [14:0] W_MEMADR   = {8'b00001000, 2'b10, 2'b00, 3'b010};
  localparam logic [14:0] W_MEMRD    = {8'b00000100, 2'b00, 2'b00, 3'b010};
  localparam logic [14:0] W_MEMWB    = {8'b00100010, 2'b00, 2'b00, 3'b010};
  localparam logic [14:0] W_MEMWR    = {8'b00010100, 2'b00, 2'b00, 3'b010};
  localparam logic [14:0] W_ALUWB    = {8'b00100001, 2'b00, 2'b00, 3'b010};
  localparam logic [14:0] W_BR_Z1    = {8'b10001000, 2'b00, 2'b01, 3'b110};
  localparam logic [14:0] W_BR_Z0    = {8'b00001000, 2'b00, 2'b01, 3'b110};
  localparam logic [14:0] W_ADDIWB   = {8'b00100000, 2'b00, 2'b00, 3'b010};
  localparam logic [14:0] W_JUMP     = {8'b10000000, 2'b00, 2'b10, 3'b010};
  localparam logic [7:0]  EXEC_HI    = 8'b00001000;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [14:0] exp_word;
    logic [31:0] exp_instret;
  } vec_t;

  vec_t vecs[$];
  int   checks_total;
  int   checks_passed;

  function automatic logic [14:0] ctrl_word();
    return {bus.pcen, bus.irwrite, bus.regwrite, bus.memwrite, bus.alusrca,
            bus.iord, bus.memtoreg, bus.regdst, bus.alusrcb, bus.pcsrc,
            bus.alucontrol};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add_row(input string name, input logic [5:0] op, input logic [5:0] funct,
                         input logic zero, input logic [14:0] w, input logic [31:0] inst);
    vec_t v;
    v.name = name; v.op = op; v.funct = funct; v.zero = zero;
    v.exp_word = w; v.exp_instret = inst;
    vecs.push_back(v);
  endtask

  // One R-type instruction: four cycles, EXECUTE carries the decoded ALU code
  task automatic add_rtype(input string name, input logic [5:0] funct,
                           input logic [2:0] aluc, input logic [31:0] inst);
    add_row({name, " fetch"},   6'b000000, funct, 1'b1, W_FETCH, inst);
    add_row({name, " decode"},  6'b000000, funct, 1'b1, W_DECODE, inst);
    add_row({name, " execute"}, 6'b000000, funct, 1'b1, {EXEC_HI, 2'b00, 2'b00, aluc}, inst);
    add_row({name, " aluwb"},   6'b000000, funct, 1'b1, W_ALUWB, inst);
  endtask

  task automatic check_instret(input string name, input logic [31:0] exp);
`ifdef MC_PERFCNT_EN
    check(name, instret, exp);
`else
    if (exp == 32'hFFFF_FFFF) $display("note: %s unused", name);
`endif
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset    = 1'b0;
    bus.op   = 6'b000000;
    bus.funct = 6'b000000;
    bus.zero = 1'b0;

    // lw: FETCH DECODE MEMADR MEMRD MEMWB
    add_row("lw fetch",   6'b100011, 6'b000000, 1'b1, W_FETCH,  0);
    add_row("lw decode",  6'b100011, 6'b000000, 1'b1, W_DECODE, 0);
    add_row("lw memadr",  6'b100011, 6'b000000, 1'b1, W_MEMADR, 0);
    add_row("lw memrd",   6'b100011, 6'b000000, 1'b1, W_MEMRD,  0);
    add_row("lw memwb",   6'b100011, 6'b000000, 1'b1, W_MEMWB,  0);
    // sw: FETCH DECODE MEMADR MEMWR
    add_row("sw fetch",   6'b101011, 6'b000000, 1'b1, W_FETCH,  1);
    add_row("sw decode",  6'b101011, 6'b000000, 1'b1, W_DECODE, 1);
    add_row("sw memadr",  6'b101011, 6'b000000, 1'b1, W_MEMADR, 1);
    add_row("sw memwr",   6'b101011, 6'b000000, 1'b1, W_MEMWR,  1);
    // R-type funct sweep
    add_rtype("r sub",  6'b100010, 3'b110, 2);
    add_rtype("r and",  6'b100100, 3'b000, 3);
    add_rtype("r or",   6'b100101, 3'b001, 4);
    add_rtype("r slt",  6'b101010, 3'b111, 5);
    add_rtype("r unk",  6'b111111, 3'b010, 6);
    add_rtype("r add",  6'b100000, 3'b010, 7);
    // beq taken / not taken
    add_row("beq1 fetch",  6'b000100, 6'b000000, 1'b1, W_FETCH,  8);
    add_row("beq1 decode", 6'b000100, 6'b000000, 1'b1, W_DECODE, 8);
    add_row("beq1 branch", 6'b000100, 6'b000000, 1'b1, W_BR_Z1,  8);
    add_row("beq0 fetch",  6'b000100, 6'b000000, 1'b0, W_FETCH,  9);
    add_row("beq0 decode", 6'b000100, 6'b000000, 1'b0, W_DECODE, 9);
    add_row("beq0 branch", 6'b000100, 6'b000000, 1'b0, W_BR_Z0,  9);
    // addi
    add_row("addi fetch",  6'b001000, 6'b000000, 1'b1, W_FETCH,  10);
    add_row("addi decode", 6'b001000, 6'b000000, 1'b1, W_DECODE, 10);
    add_row("addi exec",   6'b001000, 6'b000000, 1'b1, W_MEMADR, 10);
    add_row("addi wb",     6'b001000, 6'b000000, 1'b1, W_ADDIWB, 10);
    // j
    add_row("j fetch",     6'b000010, 6'b000000, 1'b1, W_FETCH,  11);
    add_row("j decode",    6'b000010, 6'b000000, 1'b1, W_DECODE, 11);
    add_row("j jump",      6'b000010, 6'b000000, 1'b1, W_JUMP,   11);
    // unknown op: nop, not counted
    add_row("unk fetch",   6'b111111, 6'b000000, 1'b1, W_FETCH,  12);
    add_row("unk decode",  6'b111111, 6'b000000, 1'b1, W_DECODE, 12);
    // lw interrupted by reset during MEMRD (reset part is hand-written below)
    add_row("lw2 fetch",   6'b100011, 6'b000000, 1'b1, W_FETCH,  12);
    add_row("lw2 decode",  6'b100011, 6'b000000, 1'b1, W_DECODE, 12);
    add_row("lw2 memadr",  6'b100011, 6'b000000, 1'b1, W_MEMADR, 12);
    add_row("lw2 memrd",   6'b100011, 6'b000000, 1'b1, W_MEMRD,  12);

    // Reset held for three cycles: FETCH outputs throughout
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("reset word c%0d", i), 32'(ctrl_word()), 32'(W_FETCH));
      check_instret($sformatf("reset instret c%0d", i), 0);
    end

    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      bus.op    = vecs[i].op;
      bus.funct = vecs[i].funct;
      bus.zero  = vecs[i].zero;
      #1;
      check({vecs[i].name, " word"}, 32'(ctrl_word()), 32'(vecs[i].exp_word));
      check_instret({vecs[i].name, " instret"}, vecs[i].exp_instret);
      $display("row %0d %s op=%b funct=%b zero=%b word=%b", i, vecs[i].name,
               vecs[i].op, vecs[i].funct, vecs[i].zero, ctrl_word());
    end

    // Still in MEMRD: pulse reset, must drop to FETCH at once with no write
    reset = 1'b0;
    #1;
    check("midreset word", 32'(ctrl_word()), 32'(W_FETCH));
    check("midreset regwrite", 32'(bus.regwrite), 32'd0);
    check_instret("midreset instret", 0);
    @(negedge clk);
    #1;
    check("midreset held word", 32'(ctrl_word()), 32'(W_FETCH));
    check("midreset held regwrite", 32'(bus.regwrite), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("post-reset decode", 32'(ctrl_word()), 32'(W_DECODE));
    check_instret("post-reset instret", 0);
    $display("reset pulse sequence done");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", checks_passed, checks_total);
    $fatal(1, "timeout");
  end

endmodule
